// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin arbiter that shares the FIFO write port
// (winc/wdata, back-pressured by wfull) among NUM_REQ producers in wclk.
// Optional burst locking: define FIFO_WR_ARB_BURST_EN to let one grant
// carry up to MAX_BURST consecutive words; otherwise grants rotate per word.
module fifo_wr_arbiter #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned MAX_BURST  = 4
) (
  input  logic                          wclk,
  input  logic                          wrst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata_in,
  input  logic                          wfull,
  output logic [NUM_REQ-1:0]            gnt,
  output logic                          winc,
  output logic [DATA_WIDTH-1:0]         wdata,
  output logic                          busy
);

  localparam int unsigned PTR_W = $clog2(NUM_REQ);

  // Reject unsupported configurations at elaboration
  if (NUM_REQ < 2 || NUM_REQ > 8 || MAX_BURST < 1 || MAX_BURST > 16) begin : g_param_check
    $error("fifo_wr_arbiter: NUM_REQ or MAX_BURST out of range");
  end

  typedef enum logic {
    ST_IDLE,
    ST_GRANTED
  } state_e;

  state_e             state_q;
  logic [NUM_REQ-1:0] gnt_q;
  logic [PTR_W-1:0]   rr_ptr_q;

  logic               accept;
  logic               limit_hit;
  logic               release_c;
  logic [PTR_W-1:0]   g_idx;
  logic [PTR_W-1:0]   g_next;
  logic               idle_found;
  logic [PTR_W-1:0]   idle_idx;
  logic               other_found;
  logic [PTR_W-1:0]   other_idx;

`ifdef FIFO_WR_ARB_BURST_EN
  localparam int unsigned BCNT_W = $clog2(MAX_BURST) + 1;
  logic [BCNT_W-1:0] burst_cnt_q;
  assign limit_hit = accept && (burst_cnt_q == BCNT_W'(MAX_BURST - 1));
`else
  assign limit_hit = accept;
`endif

  function automatic logic [NUM_REQ-1:0] onehot(input logic [PTR_W-1:0] idx);
    onehot = NUM_REQ'(1) << idx;
  endfunction

  assign accept    = (|(gnt_q & req)) & ~wfull;
  assign winc      = accept;
  assign gnt       = gnt_q;
  assign busy      = |gnt_q;
  assign g_next    = PTR_W'((32'(g_idx) + 32'd1) % NUM_REQ);
  assign release_c = (state_q == ST_GRANTED) && (!req[g_idx] || limit_hit);

  // Encode the one-hot grant into an index
  always_comb begin
    g_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) g_idx = PTR_W'(i);
    end
  end

  // Write data is the slice of the granted producer, zero when idle
  always_comb begin
    wdata = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_q[i]) wdata = wdata | wdata_in[i*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  // Idle search: first requester starting at rr_ptr
  always_comb begin : idle_search
    logic [PTR_W-1:0] cand;
    cand       = '0;
    idle_found = 1'b0;
    idle_idx   = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = PTR_W'((32'(rr_ptr_q) + k) % NUM_REQ);
      if (!idle_found && req[cand]) begin
        idle_found = 1'b1;
        idle_idx   = cand;
      end
    end
  end

  // Handover search: first requester after g, excluding g itself
  always_comb begin : other_search
    logic [PTR_W-1:0] cand;
    cand        = '0;
    other_found = 1'b0;
    other_idx   = '0;
    for (int unsigned k = 1; k < NUM_REQ; k++) begin
      cand = PTR_W'((32'(g_idx) + k) % NUM_REQ);
      if (!other_found && req[cand]) begin
        other_found = 1'b1;
        other_idx   = cand;
      end
    end
  end

  // Grant FSM: IDLE <-> GRANTED with same-cycle handover on release
  always_ff @(posedge wclk or posedge wrst) begin
    if (wrst) begin
      state_q     <= ST_IDLE;
      gnt_q       <= '0;
      rr_ptr_q    <= '0;
`ifdef FIFO_WR_ARB_BURST_EN
      burst_cnt_q <= '0;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (idle_found) begin
            state_q     <= ST_GRANTED;
            gnt_q       <= onehot(idle_idx);
`ifdef FIFO_WR_ARB_BURST_EN
            burst_cnt_q <= '0;
`endif
          end
        end
        ST_GRANTED: begin
          if (release_c) begin
            rr_ptr_q <= g_next;
            if (other_found) begin
              gnt_q       <= onehot(other_idx);
`ifdef FIFO_WR_ARB_BURST_EN
              burst_cnt_q <= '0;
`endif
            end else if (req[g_idx]) begin
              gnt_q       <= gnt_q;
`ifdef FIFO_WR_ARB_BURST_EN
              burst_cnt_q <= '0;
`endif
            end else begin
              gnt_q   <= '0;
              state_q <= ST_IDLE;
            end
          end
`ifdef FIFO_WR_ARB_BURST_EN
          else if (accept) begin
            burst_cnt_q <= burst_cnt_q + BCNT_W'(1);
          end
`endif
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed vectors for the FIFO write-side arbiter.
module tb_fifo_wr_arbiter;

  localparam int unsigned DW = 8;
  localparam int unsigned NR = 4;
  localparam int unsigned MB = 4;
`ifdef FIFO_WR_ARB_BURST_EN
  localparam int unsigned BL = MB;
`else
  localparam int unsigned BL = 1;
`endif

  logic              wclk = 1'b0;
  logic              wrst;
  logic [NR-1:0]     req;
  logic [NR*DW-1:0]  wdata_in;
  logic              wfull;
  logic [NR-1:0]     gnt;
  logic              winc;
  logic [DW-1:0]     wdata;
  logic              busy;

  int checks = 0;
  int errors = 0;

  logic          rec = 1'b0;
  logic [DW-1:0] got[$];

  always #5 wclk = ~wclk;

  fifo_wr_arbiter #(
    .DATA_WIDTH(DW),
    .NUM_REQ   (NR),
    .MAX_BURST (MB)
  ) dut (
    .wclk    (wclk),
    .wrst    (wrst),
    .req     (req),
    .wdata_in(wdata_in),
    .wfull   (wfull),
    .gnt     (gnt),
    .winc    (winc),
    .wdata   (wdata),
    .busy    (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge wclk);
    #1;
  endtask

  // Capture every word the FIFO would take (inputs are stable at negedge)
  always @(negedge wclk) begin
    if (rec && winc) got.push_back(wdata);
  end

  initial begin
    logic [DW-1:0] words[5];
    logic          fp[8];
    int unsigned   exp_idx;
    int unsigned   widx;

    words = '{8'hA5, 8'h5A, 8'h3C, 8'hC3, 8'h11};
    fp    = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    // Reset and quiet idle
    wrst = 1'b1; req = '0; wfull = 1'b0; wdata_in = '0;
    @(negedge wclk);
    check("rst_out", 32'({gnt, winc, busy}), 32'd0);
    next_cycle();
    wrst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge wclk);
      check("idle_out", 32'({gnt, winc, busy}), 32'd0);
      next_cycle();
    end

    // All producers requesting: rotation pattern
    for (int i = 0; i < int'(NR); i++) wdata_in[i*DW +: DW] = 8'(8'hA0 + i);
    req = 4'b1111;
    next_cycle();
    for (int unsigned k = 0; k < 12; k++) begin
      exp_idx = (k / BL) % NR;
      @(negedge wclk);
      check("rr_gnt", 32'(gnt), 32'd1 << exp_idx);
      check("rr_winc_busy", 32'({winc, busy}), 32'd3);
      check("rr_data", 32'(wdata), 32'hA0 + exp_idx);
      next_cycle();
    end
    req = '0;
    @(negedge wclk);
    check("rr_drop_winc", 32'(winc), 32'd0);
    next_cycle();
    @(negedge wclk);
    check("rr_back_idle", 32'({gnt, busy}), 32'd0);
    next_cycle();

    // Single producer 2: five words, continuous grant across the re-grant
    wdata_in[2*DW +: DW] = words[0];
    req = 4'b0100;
    next_cycle();
    for (int w = 0; w < 5; w++) begin
      @(negedge wclk);
      check("solo_gnt", 32'(gnt), 32'h4);
      check("solo_winc", 32'(winc), 32'd1);
      check("solo_data", 32'(wdata), 32'(words[w]));
      next_cycle();
      if (w < 4) wdata_in[2*DW +: DW] = words[w+1];
    end
    req = '0;
    @(negedge wclk);
    check("solo_drop_winc", 32'(winc), 32'd0);
    next_cycle();
    @(negedge wclk);
    check("solo_idle", 32'(gnt), 32'd0);
    next_cycle();

    // Producer 1 with wfull for three cycles mid-burst
    widx = 0;
    got.delete();
    rec = 1'b1;
    wdata_in[1*DW +: DW] = 8'hB0;
    req = 4'b0010;
    next_cycle();
    for (int c = 0; c < 8; c++) begin
      wfull = fp[c];
      wdata_in[1*DW +: DW] = 8'(8'hB0 + widx);
      @(negedge wclk);
      check("full_gnt", 32'(gnt), 32'h2);
      check("full_winc", 32'(winc), 32'(!fp[c]));
      next_cycle();
      if (!fp[c]) widx++;
    end
    rec = 1'b0;
    wfull = 1'b0;
    req = '0;
    check("full_word_count", 32'(got.size()), 32'd5);
    for (int i = 0; i < got.size(); i++) check("full_word", 32'(got[i]), 32'hB0 + 32'(i));
    next_cycle();

    // Reset while producer 3 is mid-burst
    wdata_in[3*DW +: DW] = 8'hC0;
    req = 4'b1000;
    next_cycle();
    @(negedge wclk);
    check("pre_rst_gnt", 32'(gnt), 32'h8);
    check("pre_rst_winc", 32'(winc), 32'd1);
    next_cycle();
    wdata_in[3*DW +: DW] = 8'hC1;
    #2;
    wrst = 1'b1;
    #1;
    check("rst_mid_out", 32'({gnt, winc, busy}), 32'd0);
    req = 4'b1001;
    wdata_in[0 +: DW] = 8'hD0;
    next_cycle();
    check("rst_hold_out", 32'({gnt, winc, busy}), 32'd0);
    next_cycle();
    wrst = 1'b0;
    next_cycle();
    @(negedge wclk);
    check("post_rst_gnt", 32'(gnt), 32'h1);
    check("post_rst_data", 32'(wdata), 32'hD0);
    next_cycle();

    // Producer 0 drops req before its first accept; producer 1 takes over
    wrst = 1'b1;
    req = '0;
    #2;
    wrst = 1'b0;
    wdata_in[1*DW +: DW] = 8'hE1;
    req = 4'b0011;
    next_cycle();
    req = 4'b0010;
    @(negedge wclk);
    check("drop_gnt", 32'(gnt), 32'h1);
    check("drop_nowrite", 32'(winc), 32'd0);
    next_cycle();
    @(negedge wclk);
    check("handover_gnt", 32'(gnt), 32'h2);
    check("handover_winc", 32'(winc), 32'd1);
    check("handover_data", 32'(wdata), 32'hE1);
    check("handover_rr_ptr", 32'(dut.rr_ptr_q), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_wr_arbiter.md
# fifo_wr_arbiter

Write-side arbiter in the `wclk` domain of the asynchronous FIFO. It shares the single FIFO write port (`winc`/`wdata`, back-pressured by `wfull`) among `NUM_REQ` independent producers. Grants rotate round-robin, with optional burst locking. It sits between the producer blocks and the FIFO write interface and contains no storage beyond its grant, pointer and burst state.

## Interface
- `DATA_WIDTH`, 8: FIFO word width; must match the FIFO.
- `NUM_REQ`, 4: number of producers, 2..8.
- `MAX_BURST`, 4: maximum words per grant when bursting is enabled, 1..16.

- `wclk`  in  1  write-domain clock (80 MHz).
- `wrst`  in  1  reset; asynchronous, active-high.
- `req`  in  NUM_REQ  per-producer request; held high with data until accepted.
- `wdata_in`  in  NUM_REQ*DATA_WIDTH  producer data; slice i is `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `wfull`  in  1  FIFO full flag, already synchronised to `wclk`.
- `gnt`  out  NUM_REQ  registered one-hot grant, or all-zero.
- `winc`  out  1  FIFO write enable.
- `wdata`  out  DATA_WIDTH  FIFO write data.
- `busy`  out  1  high whenever `gnt` is nonzero.

## Operation
- State: `gnt` register, `rr_ptr` of $clog2(NUM_REQ) bits, and `burst_cnt` of $clog2(MAX_BURST)+1 bits.
- Reset values: `gnt`=0, `rr_ptr`=0, `burst_cnt`=0. Outputs: `winc`=0, `wdata`=0, `busy`=0.
- `accept = |(gnt & req) & !wfull`, combinational.
- `winc = accept`.
- `wdata` is the `wdata_in` slice selected by `gnt`, or 0 when `gnt`=0.
- States:
  - IDLE: `gnt`=0.
  - GRANTED: `gnt` is one-hot at index g.
- IDLE -> GRANTED:
  - Taken when any `req` is high.
  - g = first requesting index searching `rr_ptr`, `rr_ptr`+1, … modulo `NUM_REQ`.
  - `burst_cnt` is cleared.
- In GRANTED, a release occurs when either:
  - `req[g]` is low, or
  - `accept` is high and the burst limit is reached (see Configuration).
- On release:
  - `rr_ptr` <= (g+1) mod `NUM_REQ`.
  - The next grant is chosen in the same cycle by searching `req` from g+1 modulo `NUM_REQ`, excluding g.
  - If no other producer is requesting and `req[g]` is still high, g is re-granted with `burst_cnt`=0.
  - Otherwise the block returns to IDLE.
- On `accept` without release: `burst_cnt` increments and `gnt` is held.
- While `wfull` is high: `gnt` is held, `winc`=0, and `burst_cnt` is unchanged. `wfull` never causes a release.
- A producer must not drop `req` or change its data while granted and not yet accepted. Dropping `req` while granted is treated as a release with no transfer.

## Timing
- Latency from `req` rising in IDLE to first write: 1 cycle. The `gnt` register is set at edge n+1, and `winc` is high during cycle n+1 if `wfull`=0.
- Back-to-back writes: one word per `wclk` while granted and not full.
- Handover to a different producer costs no idle cycle.
- A producer sees its word taken at the edge where `gnt[i] & req[i] & !wfull` is high. It presents the next word, or drops `req`, in the following cycle.
- Asynchronous reset mid-operation:
  - `gnt` clears immediately, and `winc` falls combinationally in the same cycle.
  - No partial write is issued after `wrst` asserts.
  - After `wrst` deasserts, arbitration restarts from index 0.
- `wfull` asserting in the same cycle as the last word of a burst: the word is not accepted, and the burst continues until the word is accepted.

## Configuration
- `FIFO_WR_ARB_BURST_EN` defined:
  - The burst limit is reached when `accept` is high and `burst_cnt` == `MAX_BURST`-1.
  - A granted producer can write up to `MAX_BURST` consecutive words.
- `FIFO_WR_ARB_BURST_EN` not defined:
  - The burst limit is reached on every `accept`. Grant rotates after each word.
  - `burst_cnt` logic is removed and `MAX_BURST` is ignored.

## Test plan
- Reset, then drive `req`=4'b0000 for 5 cycles -> `gnt`=0, `winc`=0, `busy`=0 throughout.
- `req`=4'b1111 held, `wfull`=0, burst enabled, `MAX_BURST`=4 -> grants 0,0,0,0,1,1,1,1,2,… with `winc` high every cycle. With burst disabled -> grants 0,1,2,3,0,…
- Only producer 2 requests, with data 0xA5,0x5A,0x3C,0xC3,0x11 -> five consecutive writes in that order. `gnt`=4'b0100 throughout, re-granted with no gap after the fourth word.
- Producer 1 granted, `wfull` high for 3 cycles mid-burst -> `winc`=0 and `gnt` held for those 3 cycles. The burst resumes with the remaining count, and no word is lost or duplicated.
- Assert `wrst` while producer 3 is granted mid-burst -> `gnt`, `winc` and `busy` drop in the same cycle. After release with `req`=4'b1001, the first grant goes to producer 0.
- Producer 0 granted drops `req` before its first accept while producer 1 requests -> next cycle `gnt`=4'b0010 and `rr_ptr`=1, with no write from producer 0.
